// File: rtl/mmt_sync_multi.sv
// Multi-channel level synchroniser with an optional per-channel stability filter
// and registered rise/fall edge detection. Channels are independent (not coherent).
module mmt_sync_multi #(
    parameter int               Width        = 8,
    parameter int               Depth        = 3,
    parameter int               FilterCycles = 0,
    parameter logic [Width-1:0] ResetVal     = '0
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [Width-1:0] in,
    output logic [Width-1:0] out,
    output logic [Width-1:0] rise,
    output logic [Width-1:0] fall
);

    logic [Width-1:0] sync_s;
    logic [Width-1:0] out_q;

    genvar gi;
    generate
        for (gi = 0; gi < Width; gi++) begin : g_chan
            logic [Depth-1:0] chain_q;

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    chain_q <= {Depth{ResetVal[gi]}};
                end else begin
                    chain_q <= {chain_q[Depth-2:0], in[gi]};
                end
            end

            assign sync_s[gi] = chain_q[Depth-1];

            if (FilterCycles == 0) begin : g_bypass
                assign out[gi] = sync_s[gi];
            end else begin : g_filter
                localparam int              CntW    = $clog2(FilterCycles + 1);
                localparam logic [CntW-1:0] CntLast = CntW'(FilterCycles - 1);

                logic [CntW-1:0] cnt_q, cnt_d;
                logic            lvl_q, lvl_d;

                // Any cycle where the synced level agrees with out restarts the count.
                always_comb begin
                    cnt_d = cnt_q;
                    lvl_d = lvl_q;
                    if (sync_s[gi] == lvl_q) begin
                        cnt_d = '0;
                    end else if (cnt_q == CntLast) begin
                        lvl_d = sync_s[gi];
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end

                always_ff @(posedge clk or negedge rstn) begin
                    if (!rstn) begin
                        cnt_q <= '0;
                        lvl_q <= ResetVal[gi];
                    end else begin
                        cnt_q <= cnt_d;
                        lvl_q <= lvl_d;
                    end
                end

                assign out[gi] = lvl_q;
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_q <= ResetVal;
        end else begin
            out_q <= out;
        end
    end

    assign rise = out & ~out_q;
    assign fall = ~out & out_q;

endmodule

// File: tb/tb_mmt_sync_multi.sv
// Directed plus randomized bench for mmt_sync_multi: a filtered instance and a
// bypass instance, both compared each edge against a sample-history reference model.
module tb_mmt_sync_multi;

    localparam int         D  = 3;
    localparam int         F  = 2;
    localparam logic [3:0] RA = 4'b0101;

    logic       clk;
    logic       rstn;
    logic [3:0] in_a, out_a, rise_a, fall_a;
    logic [3:0] in_b, out_b, rise_b, fall_b;

    int checks   = 0;
    int failures = 0;

    mmt_sync_multi #(.Width(4), .Depth(D), .FilterCycles(F), .ResetVal(RA)) u_dut_a (
        .clk (clk),
        .rstn(rstn),
        .in  (in_a),
        .out (out_a),
        .rise(rise_a),
        .fall(fall_a)
    );

    mmt_sync_multi #(.Width(4), .Depth(D), .FilterCycles(0), .ResetVal(4'b0000)) u_dut_b (
        .clk (clk),
        .rstn(rstn),
        .in  (in_b),
        .out (out_b),
        .rise(rise_b),
        .fall(fall_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: raw samples taken at each edge, the synced value seen D-1
    // edges later, and the filtered level flipping once F consecutive synced
    // values have disagreed with it.
    logic [3:0] ma_smp[$];
    logic [3:0] ma_sh[$];
    logic [3:0] ma_out, ma_prev;
    logic [3:0] mb_smp[$];
    logic [3:0] mb_out, mb_prev;

    task automatic model_reset();
        ma_smp = {};
        ma_sh  = {};
        mb_smp = {};
        for (int i = 0; i < D; i++) begin
            ma_smp.push_back(RA);
            mb_smp.push_back(4'b0000);
        end
        for (int i = 0; i < F; i++) ma_sh.push_back(RA);
        ma_out  = RA;
        ma_prev = RA;
        mb_out  = 4'b0000;
        mb_prev = 4'b0000;
    endtask

    task automatic model_edge();
        logic [3:0] s;
        bit         flip;
        if (!rstn) return;
        ma_prev = ma_out;
        for (int b = 0; b < 4; b++) begin
            flip = 1'b1;
            for (int j = 0; j < F; j++) begin
                if (ma_sh[j][b] == ma_out[b]) flip = 1'b0;
            end
            if (flip) ma_out[b] = ~ma_out[b];
        end
        ma_smp.push_back(in_a);
        s = ma_smp[ma_smp.size() - D];
        void'(ma_smp.pop_front());
        ma_sh.push_back(s);
        void'(ma_sh.pop_front());

        mb_prev = mb_out;
        mb_smp.push_back(in_b);
        mb_out = mb_smp[mb_smp.size() - D];
        void'(mb_smp.pop_front());
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        chk("a_out",  out_a,  ma_out);
        chk("a_rise", rise_a, ma_out & ~ma_prev);
        chk("a_fall", fall_a, ~ma_out & ma_prev);
        chk("b_out",  out_b,  mb_out);
        chk("b_rise", rise_b, mb_out & ~mb_prev);
        chk("b_fall", fall_b, ~mb_out & mb_prev);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
        $display("t=%0t rstn=%b in_a=%b out_a=%b rise_a=%b fall_a=%b in_b=%b out_b=%b rise_b=%b fall_b=%b",
                 $time, rstn, in_a, out_a, rise_a, fall_a, in_b, out_b, rise_b, fall_b);
    endtask

    int hi_cnt, rise_cnt, fall_cnt, rise_t, fall_t;
    logic [3:0] mask;

    initial begin
        rstn = 1'b1;
        in_a = RA;
        in_b = 4'b0000;

        // Reset state and quiet release
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        check_model();
        chk("rst_out_a", out_a, 4'b0101);
        chk("rst_edges_a", rise_a | fall_a, 4'b0000);
        tick();
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("release_no_pulse", rise_a | fall_a | rise_b | fall_b, 4'b0000);
        end

        // Rising change on bit 1: visible on the 5th sampling edge
        in_a = 4'b0111;
        for (int i = 0; i < 4; i++) tick();
        chk("lat_before", out_a, 4'b0101);
        tick();
        chk("lat_out", out_a, 4'b0111);
        chk("lat_rise", rise_a, 4'b0010);
        tick();
        chk("lat_rise_once", rise_a, 4'b0000);
        for (int i = 0; i < 4; i++) tick();

        // One-cycle glitch on bit 0 is swallowed
        in_a = 4'b0110;
        tick();
        in_a = 4'b0111;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("glitch_out0", {3'b000, out_a[0]}, 4'b0001);
            chk("glitch_fall0", {3'b000, fall_a[0]}, 4'b0000);
        end

        // Two-cycle pulse on bit 3 passes as a two-cycle output pulse
        hi_cnt = 0; rise_cnt = 0; fall_cnt = 0; rise_t = -1; fall_t = -1;
        in_a = 4'b1111;
        for (int i = 0; i < 14; i++) begin
            if (i == 2) in_a = 4'b0111;
            tick();
            if (out_a[3])  hi_cnt++;
            if (rise_a[3]) begin rise_cnt++; rise_t = i; end
            if (fall_a[3]) begin fall_cnt++; fall_t = i; end
        end
        chk("pulse_hi_cycles", 4'(hi_cnt), 4'd2);
        chk("pulse_rise_count", 4'(rise_cnt), 4'd1);
        chk("pulse_fall_count", 4'(fall_cnt), 4'd1);
        chk("pulse_gap", 4'(fall_t - rise_t), 4'd2);

        // Reset in the middle of a filter count discards the pending change
        in_a = RA;
        for (int i = 0; i < 8; i++) tick();
        in_a = 4'b0111;
        for (int i = 0; i < 4; i++) tick();
        chk("midcnt_out", out_a, 4'b0101);
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        chk("midrst_out", out_a, 4'b0101);
        chk("midrst_rise", rise_a, 4'b0000);
        chk("midrst_fall", fall_a, 4'b0000);
        in_a = RA;
        tick();
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("midrst_after", out_a, 4'b0101);
            chk("midrst_after_edges", rise_a | fall_a, 4'b0000);
        end

        // Unfiltered instance: three-edge latency both ways
        in_b = 4'b0001;
        tick();
        tick();
        chk("b_lat2_rise", out_b, 4'b0000);
        tick();
        chk("b_lat3_rise", out_b, 4'b0001);
        chk("b_rise_pulse", rise_b, 4'b0001);
        tick();
        chk("b_rise_once", rise_b, 4'b0000);
        in_b = 4'b0000;
        tick();
        tick();
        chk("b_lat2_fall", out_b, 4'b0001);
        tick();
        chk("b_lat3_fall", out_b, 4'b0000);
        chk("b_fall_pulse", fall_b, 4'b0001);
        tick();
        chk("b_fall_once", fall_b, 4'b0000);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 99) == 0) begin
                #2;
                rstn = 1'b0;
                model_reset();
                #1;
                check_model();
                tick();
                rstn = 1'b1;
            end
            for (int b = 0; b < 4; b++) mask[b] = ($urandom_range(0, 2) == 0);
            in_a = in_a ^ mask;
            for (int b = 0; b < 4; b++) mask[b] = ($urandom_range(0, 3) == 0);
            in_b = in_b ^ mask;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
